// File: rtl/dense_requant_fifo.sv
// Purpose : requantise NUM_TREES signed 32-bit dense sums (rounded >>> then 8-bit saturate) into a show-ahead FIFO.
// Latency : in_valid sampled at edge E0 -> FIFO write at E2 -> out_valid high after E2 when the FIFO was empty.
// Backpr. : input side never stalls; almost_full asks upstream to stop, writes into a full FIFO drop and set overflow.
//
// Ports:
//   clock, reset (async, active-low)
//   in_valid / pixel_vector_in[32*NUM_TREES] / shift_amt   : incoming sums, lane i at [32i+31:32i]
//   out_valid / out_ready / pixel_vector_out[8*NUM_TREES]  : head of FIFO, lane i at [8i+7:8i]
//   almost_full, overflow (sticky), overflow_clr, count
//
// Build option: define DENSE_REQUANT_RELU_EN to fuse ReLU into the saturation
// (lanes become unsigned 0..255); otherwise lanes are signed -128..127.
module dense_requant_fifo #(
  parameter int NUM_TREES  = 4,
  parameter int SHIFT_W    = 5,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_MARGIN  = 3
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             in_valid,
  input  logic [32*NUM_TREES-1:0]          pixel_vector_in,
  input  logic [SHIFT_W-1:0]               shift_amt,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [8*NUM_TREES-1:0]           pixel_vector_out,
  output logic                             almost_full,
  output logic                             overflow,
  input  logic                             overflow_clr,
  output logic [$clog2(FIFO_DEPTH):0]      count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_TH   = CW'(FIFO_DEPTH - AF_MARGIN);

  // ---------------- stage 1: rounded arithmetic shift at 33 bits ----------------
  logic               s1_vld;
  logic signed [32:0] s1_r  [NUM_TREES];
  logic signed [32:0] r_nxt [NUM_TREES];
  logic signed [32:0] rnd;
  logic signed [32:0] x_ext;
  logic signed [32:0] sum;

  always_comb begin
    rnd   = '0;
    x_ext = '0;
    sum   = '0;
    // Half-LSB bias makes the floor-shift round half toward +inf.
    if (shift_amt != '0) rnd = 33'sd1 <<< (shift_amt - SHIFT_W'(1));
    for (int i = 0; i < NUM_TREES; i++) begin
      // 33-bit sign extension keeps the bias add from wrapping at 0x7FFFFFFF.
      x_ext    = {pixel_vector_in[32*i+31], pixel_vector_in[32*i +: 32]};
      sum      = x_ext + rnd;
      r_nxt[i] = sum >>> shift_amt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_vld <= 1'b0;
      for (int i = 0; i < NUM_TREES; i++) s1_r[i] <= '0;
    end else begin
      s1_vld <= in_valid;
      for (int i = 0; i < NUM_TREES; i++) s1_r[i] <= r_nxt[i];
    end
  end

  // ---------------- stage 2: saturate to 8 bits and pack ----------------
  logic                   s2_vld;
  logic [8*NUM_TREES-1:0] s2_dat;
  logic [8*NUM_TREES-1:0] sat_dat;
  logic [7:0]             lane;

  always_comb begin
    sat_dat = '0;
    lane    = '0;
    for (int i = 0; i < NUM_TREES; i++) begin
`ifdef DENSE_REQUANT_RELU_EN
      if (s1_r[i] < 33'sd0)        lane = 8'h00;
      else if (s1_r[i] > 33'sd255) lane = 8'hFF;
      else                         lane = s1_r[i][7:0];
`else
      if (s1_r[i] < -33'sd128)     lane = 8'h80;
      else if (s1_r[i] > 33'sd127) lane = 8'h7F;
      else                         lane = s1_r[i][7:0];
`endif
      sat_dat[8*i +: 8] = lane;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s2_vld <= 1'b0;
      s2_dat <= '0;
    end else begin
      s2_vld <= s1_vld;
      s2_dat <= sat_dat;
    end
  end

  // ---------------- show-ahead FIFO ----------------
  logic [8*NUM_TREES-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CW-1:0]          count_nxt;
  logic [8*NUM_TREES-1:0] head_nxt;
  logic                   pop, full, wr_acc, drop;

  assign pop  = out_valid & out_ready;
  assign full = (count == DEPTH_C);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_acc = s2_vld & (~full | pop);
  assign drop   = s2_vld & full & ~pop;
  assign count_nxt  = count + CW'(wr_acc) - CW'(pop);
  assign rd_ptr_nxt = rd_ptr + AW'(pop);

  // Next head: the entry being written if nothing else remains, else memory.
  always_comb begin
    head_nxt = mem[rd_ptr_nxt];
    if (wr_acc && ((count - CW'(pop)) == '0)) head_nxt = s2_dat;
  end

  always_ff @(posedge clock) begin
    if (wr_acc) mem[wr_ptr] <= s2_dat;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      out_valid        <= 1'b0;
      pixel_vector_out <= '0;
      almost_full      <= 1'b0;
      overflow         <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr           <= rd_ptr_nxt;
      count            <= count_nxt;
      out_valid        <= (count_nxt != '0);
      pixel_vector_out <= (count_nxt != '0) ? head_nxt : '0;
      almost_full      <= (count_nxt >= AF_TH);
      // Set has priority over clear so a drop is never lost.
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dense_requant_fifo.sv
module tb_dense_requant_fifo;

  localparam int N  = 4;
  localparam int SW = 5;
  localparam int D  = 8;
  localparam int CW = 4;

`ifdef DENSE_REQUANT_RELU_EN
  localparam logic [31:0] EXP_LAT  = 32'hFF020019; // 25, 0, 2, 255
  localparam logic [31:0] EXP_SAT  = 32'hFF80FF00; // 0, 255, 128, 255
  localparam logic [31:0] EXP_RND  = 32'h00020000; // 0, 0, 2, 0
  localparam logic [31:0] EXP_S31  = 32'h00010001; // 1, 0, 1, 0
  localparam logic [31:0] EXP_S1   = 32'h800002FF; // 255, 2, 0, 128
`else
  localparam logic [31:0] EXP_LAT  = 32'h7F02E719; // 25, -25, 2, 127
  localparam logic [31:0] EXP_SAT  = 32'h7F7F7FFB; // -5, 127, 127, 127
  localparam logic [31:0] EXP_RND  = 32'h800200FF; // -1, 0, 2, -128
  localparam logic [31:0] EXP_S31  = 32'h0001FF01; // 1, -1, 1, 0
  localparam logic [31:0] EXP_S1   = 32'h7FFF027F; // 127, 2, -1, 127
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [32*N-1:0]   pixel_vector_in;
  logic [SW-1:0]     shift_amt;
  logic              out_valid;
  logic              out_ready;
  logic [8*N-1:0]    pixel_vector_out;
  logic              almost_full;
  logic              overflow;
  logic              overflow_clr;
  logic [CW-1:0]     count;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  dense_requant_fifo #(.NUM_TREES(N), .SHIFT_W(SW), .FIFO_DEPTH(D), .AF_MARGIN(3)) dut (
    .clock            (clock),
    .reset            (reset),
    .in_valid         (in_valid),
    .pixel_vector_in  (pixel_vector_in),
    .shift_amt        (shift_amt),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .pixel_vector_out (pixel_vector_out),
    .almost_full      (almost_full),
    .overflow         (overflow),
    .overflow_clr     (overflow_clr),
    .count            (count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [127:0] v4(input logic [31:0] l0, input logic [31:0] l1,
                                      input logic [31:0] l2, input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  // Single vector into an empty FIFO with the consumer ready: checks latency,
  // data and that the head disappears after the pop.
  task automatic run_one(input string tag, input logic [127:0] v, input logic [SW-1:0] sh,
                         input logic [31:0] exp);
    pixel_vector_in = v;
    shift_amt       = sh;
    in_valid        = 1'b1;
    out_ready       = 1'b1;
    tick();
    in_valid        = 1'b0;
    pixel_vector_in = '0;
    chk({tag, "_vld_e1"}, out_valid, 0);
    tick();
    chk({tag, "_vld_e2"}, out_valid, 0);
    tick();
    chk({tag, "_vld_e3"}, out_valid, 1);
    chk({tag, "_dat"}, pixel_vector_out, exp);
    chk({tag, "_cnt"}, count, 1);
    tick();
    chk({tag, "_vld_pop"}, out_valid, 0);
  endtask

  // Push n lane0-only values first..first+n-1 back to back, then let them land.
  task automatic push_vals(input int first, input int n);
    shift_amt = '0;
    for (int k = 0; k < n; k++) begin
      pixel_vector_in = v4(32'(first + k), 0, 0, 0);
      in_valid        = 1'b1;
      tick();
    end
    in_valid        = 1'b0;
    pixel_vector_in = '0;
    tick();
    tick();
  endtask

  task automatic drain(input string tag, input int first, input int n);
    out_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      chk({tag, "_vld"}, out_valid, 1);
      chk({tag, "_dat"}, pixel_vector_out, 32'(first + k));
      tick();
    end
    out_ready = 1'b0;
    chk({tag, "_empty"}, out_valid, 0);
    chk({tag, "_cnt0"}, count, 0);
  endtask

  initial begin
    int exp_seq;
    int exp_cnt;

    reset           = 1'b0;
    in_valid        = 1'b0;
    pixel_vector_in = '0;
    shift_amt       = '0;
    out_ready       = 1'b0;
    overflow_clr    = 1'b0;
    tick();
    tick();
    chk("rst_vld", out_valid, 0);
    chk("rst_cnt", count, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_dat", pixel_vector_out, 0);
    reset = 1'b1;
    tick();

    // Rounding / saturation vectors
    run_one("lat", v4(32'd100, 32'hFFFFFF9C, 32'd7, 32'h7FFFFFFF), 5'd2, EXP_LAT);
    run_one("sat", v4(32'hFFFFFFFB, 32'h0000012C, 32'd128, 32'd255), 5'd0, EXP_SAT);
    run_one("rnd", v4(32'hFFFFFFFA, 32'hFFFFFFFE, 32'd6, 32'hFFFFFC18), 5'd2, EXP_RND);
    run_one("s31", v4(32'h7FFFFFFF, 32'h80000000, 32'h40000000, 32'd0), 5'd31, EXP_S31);
    run_one("s1", v4(32'h7FFFFFFF, 32'd3, 32'hFFFFFFFD, 32'd255), 5'd1, EXP_S1);

    // Fill past full with the consumer stalled
    out_ready = 1'b0;
    shift_amt = '0;
    for (int t = 1; t <= 13; t++) begin
      if (t <= 10) begin
        in_valid        = 1'b1;
        pixel_vector_in = v4(32'(t), 0, 0, 0);
      end else begin
        in_valid        = 1'b0;
        pixel_vector_in = '0;
      end
      tick();
      exp_cnt = (t - 2 < 0) ? 0 : ((t - 2 > D) ? D : t - 2);
      chk("full_cnt", count, exp_cnt);
      chk("full_af", almost_full, (exp_cnt >= 5));
      chk("full_ovf", overflow, (t >= 11));
    end
    drain("full_drain", 1, 8);
    chk("full_ovf_held", overflow, 1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("ovf_clr", overflow, 0);

    // Simultaneous push and pop while full
    push_vals(40, 8);
    chk("sim_fill_cnt", count, 8);
    exp_seq = 40;
    for (int t = 1; t <= 22; t++) begin
      in_valid        = (t <= 20);
      pixel_vector_in = v4(32'(48 + t - 1), 0, 0, 0);
      out_ready       = (t >= 3);
      if (t >= 3) begin
        chk("sim_dat", pixel_vector_out, 32'(exp_seq));
        exp_seq++;
      end
      tick();
      chk("sim_cnt", count, 8);
      chk("sim_ovf", overflow, 0);
    end
    in_valid        = 1'b0;
    pixel_vector_in = '0;
    out_ready       = 1'b0;
    drain("sim_drain", exp_seq, 8);

    // Wrap-around, set-over-clear priority, and clear
    push_vals(70, 3);
    chk("wrap_cnt3", count, 3);
    drain("wrap_a", 70, 3);
    push_vals(73, 8);
    chk("wrap_cnt8", count, 8);
    chk("wrap_af", almost_full, 1);
    pixel_vector_in = v4(32'd81, 0, 0, 0);
    in_valid        = 1'b1;
    tick();
    in_valid        = 1'b0;
    pixel_vector_in = '0;
    tick();
    overflow_clr = 1'b1;   // coincides with the drop edge
    tick();
    overflow_clr = 1'b0;
    chk("ovf_set_wins", overflow, 1);
    chk("ovf_cnt", count, 8);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("ovf_clr2", overflow, 0);
    drain("wrap_b", 73, 8);

    // Async reset with 4 queued and 2 in flight
    out_ready = 1'b0;
    push_vals(90, 4);
    chk("ar_cnt4", count, 4);
    shift_amt = '0;
    pixel_vector_in = v4(32'd94, 0, 0, 0);
    in_valid = 1'b1;
    tick();
    pixel_vector_in = v4(32'd95, 0, 0, 0);
    tick();
    in_valid        = 1'b0;
    pixel_vector_in = '0;
    #2;
    reset = 1'b0;
    #1;
    chk("ar_vld", out_valid, 0);
    chk("ar_cnt", count, 0);
    chk("ar_af", almost_full, 0);
    chk("ar_ovf", overflow, 0);
    chk("ar_dat", pixel_vector_out, 0);
    tick();
    tick();
    reset = 1'b1;
    for (int t = 0; t < 5; t++) begin
      chk("ar_post_vld", out_valid, 0);
      chk("ar_post_cnt", count, 0);
      tick();
    end
    run_one("post", v4(32'd99, 0, 0, 0), 5'd0, 32'd99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dense_requant_fifo.md
Name: dense_requant_fifo

Overview:
- Sits directly downstream of the 2.5D dense stage.
- Each valid cycle it takes the NUM_TREES 32-bit signed dot-product sums, rescales them by a rounded arithmetic right shift and saturates them to 8 bits.
- It then buffers the packed 8-bit vector in a show-ahead FIFO with a valid/ready output handshake.
- Its output is the 8-bit-per-lane pixel vector format that the next layer's pixel_vector_in expects.

Parameters:
- NUM_TREES, 4, number of lanes (kernels) in the incoming vector.
- SHIFT_W, 5, width of the runtime shift-amount input (shift range 0..31).
- FIFO_DEPTH, 8, FIFO entries; must be a power of 2 and >= 4.
- AF_MARGIN, 3, almost_full asserts when count >= FIFO_DEPTH-AF_MARGIN.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  sums on pixel_vector_in are valid this cycle; there is no backpressure on this side.
- pixel_vector_in  in  32*NUM_TREES  signed sums; lane i is bits [32i+31:32i].
- shift_amt  in  SHIFT_W  right-shift amount, sampled together with in_valid.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts the head.
- pixel_vector_out  out  8*NUM_TREES  head entry; lane i is bits [8i+7:8i].
- almost_full  out  1  stall request to the upstream controller.
- overflow  out  1  sticky: a vector was dropped.
- overflow_clr  in  1  synchronous clear of overflow.
- count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset=0, asynchronous): all pipeline valids = 0, FIFO pointers and count = 0, out_valid = 0, pixel_vector_out = 0, almost_full = 0, overflow = 0.
- Stage 1 (registered), per lane, computed at 33 bits:
  - If shift_amt = 0: r = x.
  - Otherwise: r = (x + 2^(shift_amt-1)) >>> shift_amt, i.e. round half toward +inf.
  - The 33-bit add must not wrap: 0x7FFFFFFF with shift 1 gives 0x40000000.
- Stage 2 (registered): saturate r to 8 bits (range set by the optional feature) and pack the lanes.
- FIFO write: stage-2 valid writes at the next edge.
- Latency:
  - in_valid sampled at edge E0 leads to the FIFO write at E2.
  - If the FIFO was empty, out_valid = 1 in the cycle after E2 (3 edges total).
  - Empty FIFO has no bypass.
- Back-to-back in_valid gives one write per cycle. The pipeline never stalls.
- Pop: at an edge where out_valid && out_ready. The head advances and pixel_vector_out presents the next entry at the following cycle (registered, show-ahead).
- out_ready while out_valid=0: ignored.
- Full and write with no pop: the vector is dropped, overflow is set to 1, and count stays FIFO_DEPTH.
- Full and write with a simultaneous pop: the write is accepted and count is unchanged.
- overflow_clr and a drop in the same cycle: overflow = 1 (set wins).
- Pointers wrap modulo FIFO_DEPTH. count distinguishes full from empty.
- almost_full is registered from the next-count value, so it reflects the post-edge occupancy.
- Reset mid-operation: in-flight stage data and FIFO contents are discarded immediately. out_valid is low during reset and in the first cycle after release.

Optional Feature:
- Macro: DENSE_REQUANT_RELU_EN.
- Defined: ReLU is fused into stage 2. Negative r gives 0x00, r > 255 gives 0xFF, and each lane is unsigned 0..255.
- Undefined: signed saturation. r < -128 gives 0x80, r > 127 gives 0x7F, and each lane is two's-complement -128..127.
- The stage count and latency are identical in both builds.

Test Plan:
- Latency/rounding (RELU undefined): lane0 = 100, lane1 = -100, lane2 = 7, lane3 = 0x7FFFFFFF, shift = 2, in_valid for 1 cycle, out_ready = 1.
  - out_valid rises on the 3rd edge after sampling.
  - Lanes = 25, -25 (0xE7), 2, 0x7F.
  - out_valid drops after the pop.
- ReLU build: lanes -5, 300, 128, 255, shift = 0.
  - Lanes = 0x00, 0xFF, 0x80, 0xFF.
- Full/overflow (DEPTH = 8): out_ready = 0, 10 consecutive in_valid carrying values 1..10, shift = 0.
  - almost_full = 1 once count >= 5.
  - count saturates at 8 and overflow = 1.
  - Draining yields 1..8 in order; 9 and 10 are absent.
- Simultaneous push/pop at full: FIFO full, out_ready = 1 and in_valid = 1 every cycle for 20 cycles.
  - count stays 8, overflow stays 0, and the output sequence is strictly in-order.
- Wrap-around: 3 pushes, 3 pops, then 8 pushes.
  - Pointers wrap and the data reads back in order.
  - overflow_clr pulse with no concurrent drop clears a previously set overflow to 0.
- Async reset mid-stream: assert reset between edges while 2 vectors are in flight and 4 are queued.
  - out_valid, count, almost_full and overflow go to 0 immediately.
  - No stale vector appears after release.
